// File: rtl/tx_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_sequencer_if : payload-bit valid/ready handshake from the bit source. Rev 1.0
// ---------------------------------------------------------------------------
interface tx_sequencer_if;
  logic data_in;
  logic data_valid;
  logic data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface
`default_nettype wire

// File: rtl/tx_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_sequencer : QPSK symbol-rate controller (preamble, data, underrun stuffing, flush). Rev 1.0
// ---------------------------------------------------------------------------
module tx_sequencer #(
  parameter int UPSAMPLE     = 4,
  parameter int NCOEF        = 24,
  parameter int PREAMBLE_LEN = 16,
  parameter int FLUSH_LEN    = NCOEF / UPSAMPLE,
  parameter int UCNT_NBITS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  tx_sequencer_if.slave               src,
  output logic                        sym_bit_o,
  output logic                        sym_strobe_o,
  output logic [$clog2(UPSAMPLE)-1:0] phase_o,
  output logic                        filter_en_o,
  output logic                        busy_o,
  output logic                        underrun_o,
  output logic [UCNT_NBITS-1:0]       underrun_cnt_o
);

  localparam int PHASE_W = $clog2(UPSAMPLE);
  localparam int MAX_LEN = (PREAMBLE_LEN > FLUSH_LEN) ? PREAMBLE_LEN : FLUSH_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [PHASE_W-1:0]    PH_LAST    = PHASE_W'(UPSAMPLE - 1);
  localparam logic [CNT_W-1:0]      PRE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0]      FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
  localparam logic [UCNT_NBITS-1:0] UCNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_FLUSH    = 2'd3
  } state_e;

  state_e                  state_q,     state_d;
  logic [PHASE_W-1:0]      phase_q,     phase_d;
  logic [CNT_W-1:0]        sym_cnt_q,   sym_cnt_d;
  logic                    sym_bit_q,   sym_bit_d;
  logic                    strobe_q,    strobe_d;
  logic                    filter_en_q, filter_en_d;
  logic                    underrun_q,  underrun_d;
  logic [UCNT_NBITS-1:0]   ucnt_q,      ucnt_d;

  logic busy;
  logic boundary;
  logic data_slot;
  logic ready;

  // The last preamble boundary already fetches the first payload bit.
  always_comb begin
    busy      = (state_q != S_IDLE);
    boundary  = busy && (phase_q == PH_LAST);
    data_slot = (state_q == S_DATA) ||
                ((state_q == S_PREAMBLE) && (sym_cnt_q == PRE_LAST));
    ready     = enable_i && boundary && data_slot;
  end

  assign src.data_ready = ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = busy ? phase_q + 1'b1 : '0;
    sym_cnt_d   = sym_cnt_q;
    sym_bit_d   = sym_bit_q;
    strobe_d    = boundary;
    filter_en_d = busy;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;

    if (ready) begin
      if (src.data_valid) begin
        sym_bit_d = src.data_in;
      end else begin
        sym_bit_d  = 1'b0;
        underrun_d = 1'b1;
        if (ucnt_q != UCNT_MAX) begin
          ucnt_d = ucnt_q + 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        sym_bit_d = 1'b0;
        if (enable_i) begin
          state_d     = S_PREAMBLE;
          sym_cnt_d   = '0;
          sym_bit_d   = 1'b1;
          strobe_d    = 1'b1;
          filter_en_d = 1'b1;
          ucnt_d      = '0;
        end
      end
      S_PREAMBLE: begin
        if (boundary) begin
          if (sym_cnt_q == PRE_LAST) begin
            sym_cnt_d = '0;
            if (enable_i) begin
              state_d = S_DATA;
            end else begin
              state_d   = S_FLUSH;
              sym_bit_d = 1'b0;
            end
          end else begin
            // Next symbol index is odd exactly when the current one is even.
            sym_cnt_d = sym_cnt_q + 1'b1;
            sym_bit_d = sym_cnt_q[0];
          end
        end
      end
      S_DATA: begin
        if (boundary && !enable_i) begin
          state_d   = S_FLUSH;
          sym_cnt_d = '0;
          sym_bit_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (boundary) begin
          if (sym_cnt_q == FLUSH_LAST) begin
            state_d     = S_IDLE;
            sym_cnt_d   = '0;
            sym_bit_d   = 1'b0;
            strobe_d    = 1'b0;
            filter_en_d = 1'b0;
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      sym_cnt_q   <= '0;
      sym_bit_q   <= 1'b0;
      strobe_q    <= 1'b0;
      filter_en_q <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sym_cnt_q   <= sym_cnt_d;
      sym_bit_q   <= sym_bit_d;
      strobe_q    <= strobe_d;
      filter_en_q <= filter_en_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign sym_bit_o      = sym_bit_q;
  assign sym_strobe_o   = strobe_q;
  assign phase_o        = phase_q;
  assign filter_en_o    = filter_en_q;
  assign busy_o         = busy;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_sequencer : randomized scoreboard bench for tx_sequencer. Rev 1.0
// ---------------------------------------------------------------------------
module tb_tx_sequencer;

  localparam int UPS   = 4;
  localparam int PRE   = 4;
  localparam int FL    = 6;
  localparam int UCW   = 3;
  localparam int PREC  = PRE * UPS;
  localparam int UCMAX = (1 << UCW) - 1;

  typedef struct packed {
    logic           b;
    logic           u;
    logic [UCW-1:0] c;
  } sym_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic           sym_bit;
  logic           sym_strobe;
  logic [1:0]     phase;
  logic           filter_en;
  logic           busy;
  logic           underrun;
  logic [UCW-1:0] ucnt;

  tx_sequencer_if bus();

  tx_sequencer #(
    .UPSAMPLE    (UPS),
    .NCOEF       (24),
    .PREAMBLE_LEN(PRE),
    .FLUSH_LEN   (FL),
    .UCNT_NBITS  (UCW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .src           (bus),
    .sym_bit_o     (sym_bit),
    .sym_strobe_o  (sym_strobe),
    .phase_o       (phase),
    .filter_en_o   (filter_en),
    .busy_o        (busy),
    .underrun_o    (underrun),
    .underrun_cnt_o(ucnt)
  );

  always #5 clk = ~clk;

  sym_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   model_ucnt = 0;
  bit   dir_v[$];
  bit   dir_d[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sym(input bit b, input bit u);
    sym_t s;
    s.b = b;
    s.u = u;
    s.c = model_ucnt[UCW-1:0];
    exp_q.push_back(s);
  endtask

  function automatic int pick_drop(input int d);
    if (d == 0) return int'($urandom_range(1, PREC - 1));
    return PREC - 1 + UPS * d - int'($urandom_range(0, UPS - 1));
  endfunction

  task automatic do_abort();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs_zero",
          int'({sym_bit, sym_strobe, phase, filter_en, busy, underrun, ucnt, bus.data_ready}), 0);
    exp_q.delete();
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("after_abort_idle", int'({busy, filter_en, sym_strobe}), 0);
  endtask

  // One transmission: d payload symbols offered, enable low from cycle 'drop'.
  task automatic run(input int d, input bit restart, input int drop,
                     input int abort_c, input bit use_dir);
    int last_c;
    bit en_c, rdy_exp, v, dbit;
    last_c = PREC + UPS * d + UPS * FL;
    enable = 1'b1;
    bus.data_valid = 1'($urandom);
    bus.data_in    = 1'($urandom);
    tick();
    model_ucnt = 0;
    for (int k = 0; k < PRE; k++) push_sym(k % 2 == 0, 1'b0);
    for (int c = 0; c < last_c; c++) begin
      check("busy", int'(busy), 1);
      check("filter_en", int'(filter_en), 1);
      check("sym_strobe", int'(sym_strobe), int'(c % UPS == 0));
      check("phase", int'(phase), c % UPS);
      if (c == abort_c) begin
        do_abort();
        return;
      end
      en_c    = (c < drop) || (restart && c >= PREC + UPS * d);
      v       = 1'($urandom);
      dbit    = 1'($urandom);
      rdy_exp = en_c && c >= PREC - 1 && ((c - (PREC - 1)) % UPS == 0) && c < PREC + UPS * d;
      if (rdy_exp && use_dir && dir_v.size() > 0) begin
        v    = dir_v.pop_front();
        dbit = dir_d.pop_front();
      end
      enable         = en_c;
      bus.data_valid = v;
      bus.data_in    = dbit;
      #1;
      check("data_ready", int'(bus.data_ready), int'(rdy_exp));
      if (rdy_exp) begin
        if (v) begin
          push_sym(dbit, 1'b0);
        end else begin
          if (model_ucnt < UCMAX) model_ucnt++;
          push_sym(1'b0, 1'b1);
        end
      end
      if (c == PREC - 1 + UPS * d) begin
        for (int k = 0; k < FL; k++) push_sym(1'b0, 1'b0);
      end
      tick();
    end
    check("idle_outputs", int'({busy, filter_en, sym_strobe, sym_bit, phase, underrun, bus.data_ready}), 0);
    check("idle_underrun_cnt", int'(ucnt), model_ucnt);
    if (!restart) begin
      enable = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  // Monitor: every symbol strobe is matched against the next expected symbol.
  always @(negedge clk) begin
    sym_t s;
    if (rst_n === 1'b1) begin
      if (sym_strobe) begin
        check("sb_has_entry", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          s = exp_q.pop_front();
          check("sym_bit", int'(sym_bit), int'(s.b));
          check("underrun", int'(underrun), int'(s.u));
          check("underrun_cnt", int'(ucnt), int'(s.c));
        end
      end else begin
        check("underrun_off_strobe", int'(underrun), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    bit rs;
    int d;
    rst_n          = 1'b0;
    enable         = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({sym_bit, sym_strobe, phase, filter_en, busy, underrun, ucnt, bus.data_ready}), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_after_reset",
            int'({sym_bit, sym_strobe, phase, filter_en, busy, underrun, ucnt, bus.data_ready}), 0);
    end

    dir_v = '{1, 1, 1, 1};
    dir_d = '{1, 1, 0, 1};
    run(4, 1'b0, PREC - 1 + UPS * 4 - 2, -1, 1'b1);

    dir_v = '{1, 0, 0, 1};
    dir_d = '{0, 1, 1, 1};
    run(4, 1'b0, PREC - 1 + UPS * 4 - 1, -1, 1'b1);
    check("underrun_cnt_two", int'(ucnt), 2);

    run(0, 1'b1, 7, -1, 1'b0);
    dir_v = '{0, 0, 0};
    dir_d = '{1, 1, 1};
    run(3, 1'b1, pick_drop(3), -1, 1'b1);
    run(2, 1'b0, pick_drop(2), -1, 1'b0);

    dir_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    dir_d = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run(10, 1'b0, pick_drop(10), -1, 1'b1);
    check("underrun_cnt_saturated", int'(ucnt), UCMAX);

    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(0, 8));
      rs = (i < 7) ? 1'($urandom) : 1'b0;
      run(d, rs, pick_drop(d), -1, 1'b0);
    end

    run(3, 1'b0, pick_drop(3), PREC + 2, 1'b0);
    run(1, 1'b0, pick_drop(1), -1, 1'b0);

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_sequencer.md
# tx_sequencer

Symbol-rate controller for the QPSK transmit polyphase filter. It starts and stops transmission, generates the upsampling phase and the symbol strobe, and inserts a fixed preamble. It pulls payload bits from an upstream source over a valid/ready handshake, stuffs symbols on underrun, and drains the filter with flush symbols before going idle. It sits between the bit source (PRBS or data framer) and the filter bit input.

## Interface

**Parameters**
- UPSAMPLE, 4: samples per symbol; power of two, ≥2.
- NCOEF, 24: filter taps; multiple of UPSAMPLE.
- PREAMBLE_LEN, 16: preamble length in symbols, ≥1.
- FLUSH_LEN, NCOEF/UPSAMPLE: flush length in symbols, ≥1.
- UCNT_NBITS, 16: underrun counter width.

**Ports**
- clk, input, 1: system clock; everything is on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: run request; level-sensitive.
- data_in, input, 1: payload bit.
- data_valid, input, 1: data_in is valid.
- data_ready, output, 1: combinational; a bit is consumed on a cycle with data_valid && data_ready.
- sym_bit, output, 1: registered bit driven to the filter input.
- sym_strobe, output, 1: registered; high in the first cycle (phase 0) of every symbol while busy.
- phase, output, $clog2(UPSAMPLE): registered sample phase within the symbol.
- filter_en, output, 1: registered; high in PREAMBLE, DATA and FLUSH.
- busy, output, 1: state != IDLE.
- underrun, output, 1: registered one-cycle pulse at phase 0 of each stuffed symbol.
- underrun_cnt, output, UCNT_NBITS: saturating count of stuffed symbols.

## Operation

**States:** IDLE, PREAMBLE, DATA, FLUSH.

**Reset value of every output:** 0. State resets to IDLE and all counters to 0. Reset during operation aborts immediately; there is no flush.

**Symbol boundary** is a cycle with busy and phase == UPSAMPLE-1.
- phase increments modulo UPSAMPLE every busy cycle.
- phase is held at 0 in IDLE.

**IDLE**
- enable == 1 → next cycle: PREAMBLE, phase = 0, sym_bit = 1, sym_strobe = 1.
- sym_cnt = 0 and underrun_cnt = 0 on this transition.

**PREAMBLE**
- Emits the alternating sequence 1, 0, 1, 0, …, one value per symbol.
- sym_cnt counts symbols.
- At the boundary of symbol PREAMBLE_LEN-1:
  - enable == 1 → DATA.
  - enable == 0 → FLUSH.

**DATA**
- data_ready = enable && at a symbol boundary. Also high at the final preamble boundary when enable == 1.
- At a boundary with enable == 1:
  - data_valid == 1: sym_bit ← data_in.
  - data_valid == 0: sym_bit ← 0, underrun pulses next cycle, underrun_cnt increments and saturates at all-ones.
- At a boundary with enable == 0 → FLUSH. No bit is consumed.

**FLUSH**
- sym_bit = 0 for FLUSH_LEN symbols.
- enable is ignored.
- After the last boundary → IDLE: filter_en = 0, sym_strobe = 0, sym_bit = 0.

**Restart:** if enable == 1 in the first IDLE cycle, PREAMBLE restarts on the following cycle. The minimum IDLE time is 1 cycle.

## Timing

- enable sampled high in IDLE at edge N → filter_en, busy and sym_strobe are high in cycle N+1.
- Preamble occupies exactly PREAMBLE_LEN·UPSAMPLE cycles.
- First data_ready is in cycle N + PREAMBLE_LEN·UPSAMPLE. That is the last preamble cycle, phase UPSAMPLE-1.
- A bit accepted at edge M appears on sym_bit in cycle M+1, with sym_strobe = 1 and phase = 0. It holds for UPSAMPLE cycles.
- data_ready is high in at most 1 of every UPSAMPLE cycles. data_valid outside that cycle has no effect.
- enable falling takes effect only at the next boundary; the current symbol always completes.
- Flush occupies exactly FLUSH_LEN·UPSAMPLE cycles. busy then falls at the edge after the last flush boundary.
- Simultaneous events:
  - enable = 0 at a boundary: FLUSH wins; data_ready stays low.
  - underrun_cnt at saturation: holds value while underrun still pulses.

## Test plan

Bench parameters: UPSAMPLE = 4, PREAMBLE_LEN = 4, FLUSH_LEN = 6.

1. **Reset/idle:** hold rst = 0, then release with enable = 0 for 20 cycles → all outputs 0, phase 0.
2. **Preamble and start:** raise enable, data_valid = 1, data_in sequence 1,1,0,1.
   - sym_bit shows 1,0,1,0 for 4 cycles each.
   - First data_ready at cycle 16 after enable.
   - Then sym_bit shows 1,1,0,1.
   - sym_strobe pulses every 4 cycles.
3. **Underrun:** in DATA, drop data_valid for 2 boundaries → 2 stuffed zero symbols, 2 underrun pulses, underrun_cnt = 2, no bits consumed.
4. **Stop:** drop enable mid-symbol (phase 1).
   - Symbol completes.
   - 6 zero symbols (24 cycles) follow.
   - Then busy = 0 and filter_en = 0.
   - No data_ready during the flush.
5. **Early stop / restart:**
   - enable low during PREAMBLE → all 4 preamble symbols complete, then FLUSH.
   - enable held high through FLUSH → IDLE for exactly 1 cycle, then PREAMBLE restarts and underrun_cnt clears.
6. **Async reset mid-DATA:** assert rst at phase 2 → all outputs 0 immediately, with no clock edge needed, and state is IDLE.
